// File: rtl/reg_bus_test_pkg.sv
// Shared types, constants and address decode for the register-bus test slave.
// REG_TEST_ACCESS_COUNT_EN (optional) adds write/read access counters after the scratch words.
package reg_bus_test_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam int unsigned ID_IDX           = 0;
  localparam logic [63:0] ID_VALUE_DEFAULT = 64'hAAAA_5555;

  // Concrete 32-bit bus structs so the slave also elaborates on its own.
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_default_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_default_t;

  typedef struct packed {
    logic [7:0] idx;
    logic       is_cnt;
    logic       error;
  } decode_t;

  function automatic decode_t decode_access(input logic [63:0] addr, input int unsigned ofs,
                                            input logic write, input int unsigned num_regs,
                                            input logic cnt_en);
    decode_t     d;
    logic [63:0] mask;
    logic        misaligned;
    int unsigned limit;
    d.idx      = 8'(addr >> ofs);
    mask       = (64'd1 << ofs) - 64'd1;
    misaligned = (addr & mask) != 64'd0;
    limit      = cnt_en ? num_regs + 2 : num_regs;
    d.is_cnt   = cnt_en && (32'(d.idx) >= num_regs) && (32'(d.idx) < num_regs + 2);
    d.error    = misaligned || (32'(d.idx) >= limit) ||
                 (write && ((d.idx == 8'(ID_IDX)) || d.is_cnt));
    return d;
  endfunction

endpackage

// File: rtl/reg_bus_test_wait_ctrl.sv
// Wait-state controller: captures a request in IDLE, counts down in WAIT, pulses respond in RESP.
module reg_bus_test_wait_ctrl import reg_bus_test_pkg::*; #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  output logic capture_o,
  output logic respond_o
);

  state_e     state_q;
  logic [3:0] cnt_q;
  logic       respond_q;

  assign capture_o = (state_q == IDLE) && valid_i;
  assign respond_o = respond_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      respond_q <= 1'b0;
    end else begin
      respond_q <= 1'b0;
      unique case (state_q)
        IDLE: if (valid_i) begin
          state_q <= WAIT;
          cnt_q   <= 4'(WAIT_CYCLES - 1);
        end
        WAIT: if (cnt_q == 4'd0) begin
          state_q   <= RESP;
          respond_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/reg_bus_test_regfile.sv
// Register-bus test slave: read-only ID word, byte-strobed scratch words, optional wait states.
// REG_TEST_ACCESS_COUNT_EN adds read-only wr_cnt/rd_cnt words at NUM_REGS and NUM_REGS+1.
module reg_bus_test_regfile import reg_bus_test_pkg::*; #(
  parameter type                   reg_req_t   = reg_req_default_t,
  parameter type                   reg_rsp_t   = reg_rsp_default_t,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           NUM_REGS    = 8,
  parameter int unsigned           WAIT_CYCLES = 0,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = DATA_WIDTH'(ID_VALUE_DEFAULT)
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  reg_req_t reg_req_i,
  output reg_rsp_t reg_rsp_o
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFS    = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(NUM_REGS);
`ifdef REG_TEST_ACCESS_COUNT_EN
  localparam logic CNT_EN = 1'b1;
`else
  localparam logic CNT_EN = 1'b0;
`endif

  logic                  capture, respond;
  logic [ADDR_WIDTH-1:0] lat_addr_q, act_addr;
  logic                  lat_write_q, act_write;
  logic [DATA_WIDTH-1:0] lat_wdata_q, act_wdata;
  logic [STRB_W-1:0]     lat_wstrb_q, act_wstrb;
  decode_t               dec;
  logic [IDX_W-1:0]      idx_w;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] rd_data, cnt_rdata, rdata_q;
  logic                  error_q;

  if (WAIT_CYCLES > 0) begin : g_wait
    reg_bus_test_wait_ctrl #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait_ctrl (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .valid_i  (reg_req_i.valid),
      .capture_o(capture),
      .respond_o(respond)
    );
  end else begin : g_nowait
    assign capture = 1'b0;
    assign respond = reg_req_i.valid;
  end

  // With wait states the latched copy is authoritative; bus changes during WAIT are ignored.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lat_addr_q  <= '0;
      lat_write_q <= 1'b0;
      lat_wdata_q <= '0;
      lat_wstrb_q <= '0;
    end else if (capture) begin
      lat_addr_q  <= reg_req_i.addr;
      lat_write_q <= reg_req_i.write;
      lat_wdata_q <= reg_req_i.wdata;
      lat_wstrb_q <= reg_req_i.wstrb;
    end
  end

  assign act_addr  = (WAIT_CYCLES > 0) ? lat_addr_q  : reg_req_i.addr;
  assign act_write = (WAIT_CYCLES > 0) ? lat_write_q : reg_req_i.write;
  assign act_wdata = (WAIT_CYCLES > 0) ? lat_wdata_q : reg_req_i.wdata;
  assign act_wstrb = (WAIT_CYCLES > 0) ? lat_wstrb_q : reg_req_i.wstrb;

  assign dec   = decode_access(64'(act_addr), OFS, act_write, NUM_REGS, CNT_EN);
  assign idx_w = dec.idx[IDX_W-1:0];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (respond && act_write && !dec.error) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (act_wstrb[b]) regs_q[idx_w][b*8 +: 8] <= act_wdata[b*8 +: 8];
      end
    end
  end

`ifdef REG_TEST_ACCESS_COUNT_EN
  logic [DATA_WIDTH-1:0] wr_cnt_q, rd_cnt_q;

  // Counters advance at completion, so a counter read returns the value before its own increment.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else if (respond && !dec.error) begin
      if (act_write) wr_cnt_q <= wr_cnt_q + DATA_WIDTH'(1);
      else           rd_cnt_q <= rd_cnt_q + DATA_WIDTH'(1);
    end
  end

  assign cnt_rdata = (dec.idx == 8'(NUM_REGS)) ? wr_cnt_q : rd_cnt_q;
`else
  assign cnt_rdata = '0;
`endif

  always_comb begin
    rd_data = '0;
    if (!dec.error) begin
      if (dec.idx == 8'(ID_IDX)) rd_data = ID_VALUE;
      else if (dec.is_cnt)       rd_data = cnt_rdata;
      else                       rd_data = regs_q[idx_w];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      rdata_q <= rd_data;
      error_q <= dec.error;
    end
  end

  always_comb begin
    reg_rsp_o = '0;
    if (WAIT_CYCLES > 0) begin
      reg_rsp_o.ready = respond;
      reg_rsp_o.rdata = respond ? rdata_q : '0;
      reg_rsp_o.error = respond & error_q;
    end else begin
      reg_rsp_o.ready = reg_req_i.valid;
      reg_rsp_o.rdata = reg_req_i.valid ? rd_data : '0;
      reg_rsp_o.error = reg_req_i.valid & dec.error;
    end
  end

endmodule

// File: tb/tb_reg_bus_test_regfile.sv
// Scoreboard bench for reg_bus_test_regfile: one zero-wait instance and one three-wait instance.
// Counter checks follow REG_TEST_ACCESS_COUNT_EN.
module tb_reg_bus_test_regfile;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } rsp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        error;
    logic        chk_data;
  } exp_t;

  logic clk = 1'b0;
  logic rst0_n, rst3_n;
  req_t req0, req3;
  rsp_t rsp0, rsp3;
  exp_t sb0[$];
  exp_t sb3[$];
  int   tests  = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  reg_bus_test_regfile #(
    .reg_req_t(req_t), .reg_rsp_t(rsp_t), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .NUM_REGS(8), .WAIT_CYCLES(0), .ID_VALUE(32'hAAAA_5555)
  ) dut0 (.clk_i(clk), .rst_ni(rst0_n), .reg_req_i(req0), .reg_rsp_o(rsp0));

  reg_bus_test_regfile #(
    .reg_req_t(req_t), .reg_rsp_t(rsp_t), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .NUM_REGS(8), .WAIT_CYCLES(3), .ID_VALUE(32'hAAAA_5555)
  ) dut3 (.clk_i(clk), .rst_ni(rst3_n), .reg_req_i(req3), .reg_rsp_o(rsp3));

  // Each call occupies exactly one cycle, so consecutive calls are back-to-back transfers.
  task automatic xact0(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [31:0] exp_rdata, input logic exp_err,
                       input string name);
    exp_t e;
    sb0.push_back('{rdata: exp_rdata, error: exp_err, chk_data: (!wr || exp_err)});
    req0 = '{addr: addr, write: wr, wdata: wdata, wstrb: strb, valid: 1'b1};
    @(negedge clk);
    e = sb0.pop_front();
    tests++;
    if (rsp0.ready !== 1'b1) begin
      failed++;
      $display("[TB] FAIL %s ready: got %b expected 1", name, rsp0.ready);
    end
    tests++;
    if (rsp0.error !== e.error) begin
      failed++;
      $display("[TB] FAIL %s error: got %b expected %b", name, rsp0.error, e.error);
    end
    if (e.chk_data) begin
      tests++;
      if (rsp0.rdata !== e.rdata) begin
        failed++;
        $display("[TB] FAIL %s rdata: got %h expected %h", name, rsp0.rdata, e.rdata);
      end
    end
    @(posedge clk);
    #1 req0 = '0;
  endtask

  task automatic xact3(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [31:0] exp_rdata, input logic exp_err,
                       input logic corrupt, input string name);
    exp_t e;
    int   n    = 0;
    bit   seen = 0;
    sb3.push_back('{rdata: exp_rdata, error: exp_err, chk_data: (!wr || exp_err)});
    req3 = '{addr: addr, write: wr, wdata: wdata, wstrb: strb, valid: 1'b1};
    while (!seen && n < 20) begin
      @(negedge clk);
      if (rsp3.ready === 1'b1) seen = 1;
      else begin
        n++;
        if (corrupt && n == 2) begin
          req3.wdata = ~wdata;
          req3.addr  = addr + 32'd4;
          req3.wstrb = 4'hF;
        end
      end
    end
    e = sb3.pop_front();
    tests++;
    if (!seen) begin
      failed++;
      $display("[TB] FAIL %s timeout: no ready within 20 cycles", name);
    end else begin
      if (n != 4) begin
        failed++;
        $display("[TB] FAIL %s latency: got %0d cycles expected 4", name, n);
      end
      tests++;
      if (rsp3.error !== e.error) begin
        failed++;
        $display("[TB] FAIL %s error: got %b expected %b", name, rsp3.error, e.error);
      end
      if (e.chk_data) begin
        tests++;
        if (rsp3.rdata !== e.rdata) begin
          failed++;
          $display("[TB] FAIL %s rdata: got %h expected %h", name, rsp3.rdata, e.rdata);
        end
      end
    end
    @(posedge clk);
    #1 req3 = '0;
    @(negedge clk);
    tests++;
    if (rsp3.ready !== 1'b0) begin
      failed++;
      $display("[TB] FAIL %s ready width: got %b one cycle after RESP expected 0", name, rsp3.ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst0_n = 1'b0;
    rst3_n = 1'b0;
    req0   = '0;
    req3   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (rsp0 !== '0) begin
      failed++;
      $display("[TB] FAIL reset_rsp0: got %h expected 0", rsp0);
    end
    tests++;
    if (rsp3 !== '0) begin
      failed++;
      $display("[TB] FAIL reset_rsp3: got %h expected 0", rsp3);
    end
    @(posedge clk);
    #1;
    rst0_n = 1'b1;
    rst3_n = 1'b1;
    xact0(32'h0, 1'b0, '0, 4'h0, 32'hAAAA_5555, 1'b0, "read_id");
    xact0(32'h4, 1'b0, '0, 4'h0, 32'h0, 1'b0, "read_w1_reset");
  endtask

  task automatic test_strobes();
    xact0(32'h8, 1'b1, 32'hFFFF_FFFF, 4'hF, '0, 1'b0, "write_w2_ones");
    xact0(32'h8, 1'b1, 32'h1234_5678, 4'b0101, '0, 1'b0, "write_w2_strb");
    xact0(32'h8, 1'b0, '0, 4'h0, 32'hFF34_FF78, 1'b0, "read_w2_strb");
    xact0(32'h8, 1'b1, 32'h0000_0000, 4'h0, '0, 1'b0, "write_w2_nostrb");
    xact0(32'h8, 1'b0, '0, 4'h0, 32'hFF34_FF78, 1'b0, "read_w2_nostrb");
  endtask

  task automatic test_errors();
    xact0(32'h0, 1'b1, 32'h1111_1111, 4'hF, 32'h0, 1'b1, "write_id");
    xact0(32'h0, 1'b0, '0, 4'h0, 32'hAAAA_5555, 1'b0, "read_id_after_write");
    xact0(32'h28, 1'b0, '0, 4'h0, 32'h0, 1'b1, "read_out_of_range");
    xact0(32'h6, 1'b0, '0, 4'h0, 32'h0, 1'b1, "read_misaligned");
    xact0(32'h9, 1'b1, 32'h0, 4'hF, 32'h0, 1'b1, "write_misaligned");
    xact0(32'h8, 1'b0, '0, 4'h0, 32'hFF34_FF78, 1'b0, "read_w2_after_errors");
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i < 8; i++)
      xact0(32'(i * 4), 1'b1, 32'hA5A5_0000 | 32'(i), 4'hF, '0, 1'b0, "b2b_write");
    for (int i = 1; i < 8; i++)
      xact0(32'(i * 4), 1'b0, '0, 4'h0, 32'hA5A5_0000 | 32'(i), 1'b0, "b2b_read");
    xact0(32'h1C, 1'b1, 32'h0BAD_F00D, 4'hF, '0, 1'b0, "raw_write");
    xact0(32'h1C, 1'b0, '0, 4'h0, 32'h0BAD_F00D, 1'b0, "raw_read");
  endtask

  task automatic test_wait_states();
    xact3(32'h0, 1'b0, '0, 4'h0, 32'hAAAA_5555, 1'b0, 1'b0, "w3_read_id");
    xact3(32'h10, 1'b1, 32'hCAFE_F00D, 4'hF, '0, 1'b0, 1'b1, "w3_write_corrupted_bus");
    xact3(32'h10, 1'b0, '0, 4'h0, 32'hCAFE_F00D, 1'b0, 1'b0, "w3_read_latched");
    xact3(32'h14, 1'b0, '0, 4'h0, 32'h0, 1'b0, 1'b0, "w3_read_untouched");
    xact3(32'h0, 1'b1, 32'h0, 4'hF, 32'h0, 1'b1, 1'b0, "w3_write_id");
  endtask

  task automatic test_reset_mid_wait();
    int ready_seen = 0;
    xact3(32'hC, 1'b1, 32'h1111_1111, 4'hF, '0, 1'b0, 1'b0, "w3_prefill");
    req3 = '{addr: 32'hC, write: 1'b1, wdata: 32'hDEAD_BEEF, wstrb: 4'hF, valid: 1'b1};
    repeat (2) @(negedge clk);
    rst3_n = 1'b0;
    @(posedge clk);
    #1;
    rst3_n = 1'b1;
    req3   = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp3.ready === 1'b1) ready_seen++;
    end
    tests++;
    if (ready_seen != 0) begin
      failed++;
      $display("[TB] FAIL reset_mid_wait ready: got %0d pulses expected 0", ready_seen);
    end
    @(posedge clk);
    #1;
    xact3(32'hC, 1'b0, '0, 4'h0, 32'h0, 1'b0, 1'b0, "w3_read_after_reset");
  endtask

  task automatic test_counters();
    rst0_n = 1'b0;
    req0   = '0;
    repeat (2) @(posedge clk);
    #1 rst0_n = 1'b1;
`ifdef REG_TEST_ACCESS_COUNT_EN
    xact0(32'h4, 1'b1, 32'h1, 4'hF, '0, 1'b0, "cnt_wr1");
    xact0(32'h8, 1'b1, 32'h2, 4'hF, '0, 1'b0, "cnt_wr2");
    xact0(32'hC, 1'b1, 32'h3, 4'hF, '0, 1'b0, "cnt_wr3");
    xact0(32'h4, 1'b0, '0, 4'h0, 32'h1, 1'b0, "cnt_rd1");
    xact0(32'h8, 1'b0, '0, 4'h0, 32'h2, 1'b0, "cnt_rd2");
    xact0(32'h24, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, "cnt_write_ro");
    xact0(32'h20, 1'b0, '0, 4'h0, 32'd3, 1'b0, "cnt_wr_cnt");
    xact0(32'h24, 1'b0, '0, 4'h0, 32'd3, 1'b0, "cnt_rd_cnt");
    xact0(32'h24, 1'b0, '0, 4'h0, 32'd4, 1'b0, "cnt_rd_cnt_again");
`else
    xact0(32'h20, 1'b0, '0, 4'h0, 32'h0, 1'b1, "nocnt_read_20");
    xact0(32'h24, 1'b0, '0, 4'h0, 32'h0, 1'b1, "nocnt_read_24");
    xact0(32'h4, 1'b0, '0, 4'h0, 32'h0, 1'b0, "nocnt_w1_cleared");
`endif
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst0_n = 1'b0;
    rst3_n = 1'b0;
    req0   = '0;
    req3   = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_strobes();
    test_errors();
    test_back_to_back();
    test_wait_states();
    test_reset_mid_wait();
    test_counters();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
